vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync logic inside tt_um_vga_example.
- Generates hsync/vsync, display-enable, pixel coordinates and frame/line strobes for any mode defined by parameters.
- Adds a configurable pixel-clock divider, selectable sync polarity and run/freeze control.
- Sits between the top-level clock/reset and the pixel-colour logic driving uo_out.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 1, clk cycles per pixel (>=1)
CW, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  1 = run, 0 = freeze all timing state
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
display_on  out  1  high while (hpos,vpos) is in the active area and block is running
hpos  out  CW  current pixel column, 0..H_TOTAL-1
vpos  out  CW  current line, 0..V_TOTAL-1
pix_tick  out  1  one-clk strobe marking each pixel advance
line_start  out  1  one-clk strobe when hpos wraps to 0
frame_start  out  1  one-clk strobe when (hpos,vpos) wraps to (0,0)

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Reset (async, rst_n=0):
  - hpos=0, vpos=0, divider=0, state=IDLE.
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL.
  - display_on, pix_tick, line_start and frame_start all 0.
- Divider:
  - Counts 0..CLK_DIV-1 only while ena=1.
  - pix_tick=1 in the cycle after the divider reaches CLK_DIV-1 (registered).
  - With CLK_DIV=1, pix_tick=1 every cycle that ena was 1 in the prior cycle.
- State machine:
  - IDLE to RUN on the first pixel advance. RUN is never left except by reset.
  - In IDLE, display_on=0 and both syncs are held inactive.
- Pixel advance: occurs on the divider terminal count with ena=1.
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0.
- Output timing:
  - All outputs are registered and coherent: hsync, vsync and display_on always correspond to the hpos/vpos values presented in the same cycle.
  - No combinational path from ena to any output.
- Sync windows:
  - hsync active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
- display_on = RUN && hpos<H_ACTIVE && vpos<V_ACTIVE.
- Strobes:
  - line_start: one clk, coincident with the cycle hpos becomes 0 via wrap.
  - frame_start: one clk, coincident with the cycle hpos and vpos both become 0 via wrap. line_start is also 1 in that cycle.
  - Neither strobe fires on leaving reset.
- ena deasserted:
  - Counters, divider, syncs and display_on hold their values.
  - pix_tick, line_start and frame_start are forced 0.
  - On reassertion, counting resumes from the held divider value; no positions are skipped or repeated.
- Reset mid-frame: immediate return to the reset values, including IDLE.

Test Plan:
1. Defaults, CLK_DIV=1, ena=1 after reset: hsync low exactly for hpos 656..751 (96 clks per line); line period 800 clks; first hpos=1 one clk after the first enabled edge.
2. Defaults, full frame: vsync low for vpos 490..491; frame_start period exactly 420000 clks; display_on high count per frame = 307200.
3. CLK_DIV=4: pix_tick every 4th clk; each hpos value held 4 clks; line period 3200 clks.
4. H_SYNC_POL=1, V_SYNC_POL=1, small mode (H 8/2/2/2, V 4/1/1/1): hsync high for hpos 10..11 only; frame_start every 14*7=98 pixels.
5. ena dropped at hpos=700, vpos=100 for 37 clks: hpos/vpos/hsync frozen and strobes 0; next pixel after resume is hpos=701.
6. rst_n pulsed at hpos=300, vpos=200: outputs return to reset values immediately (asynchronous), display_on=0, and no frame_start is issued on exit from reset.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces hsync/vsync, display enable, pixel coordinates and line/frame
// strobes for any mode set by parameters. It has a pixel-clock divider,
// selectable sync polarity and a run/freeze input.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   ena           1 = run, 0 = freeze all timing state
//   hsync, vsync  sync outputs; the active level comes from H_SYNC_POL / V_SYNC_POL
//   display_on    high while (hpos,vpos) is inside the visible area
//   hpos, vpos    current pixel column / line
//   pix_tick      one-clk strobe for each pixel advance
//   line_start    one-clk strobe when hpos wraps to 0
//   frame_start   one-clk strobe when (hpos,vpos) wraps to (0,0)
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned H_SYNC_POL = 0,
    parameter int unsigned V_SYNC_POL = 0,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned CW         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    // Inclusive bounds, so no constant ever has to reach H_TOTAL or V_TOTAL.
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON      = 1'(H_SYNC_POL);
    localparam logic          VS_ON      = 1'(V_SYNC_POL);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;

    logic          div_tc;
    logic          adv;
    logic          h_wrap;
    logic          v_wrap;
    logic [DW-1:0] div_nxt;
    logic [CW-1:0] hpos_d;
    logic [CW-1:0] vpos_d;
    logic          run_d;
    logic          hs_win;
    logic          vs_win;
    logic          act_win;

    // Next divider and position values, plus the windows decoded from them.
    // The windows are registered together with the position, so hsync,
    // vsync and display_on always match the hpos/vpos presented beside them.
    always_comb begin
        div_tc  = 1'b0;
        adv     = 1'b0;
        h_wrap  = 1'b0;
        v_wrap  = 1'b0;
        div_nxt = div_cnt;
        hpos_d  = hpos;
        vpos_d  = vpos;
        run_d   = (state == RUN);
        hs_win  = 1'b0;
        vs_win  = 1'b0;
        act_win = 1'b0;

        div_tc = (div_cnt == DIV_LAST);
        adv    = ena && div_tc;
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);

        if (ena) begin
            div_nxt = div_tc ? '0 : DW'(div_cnt + 1'b1);
        end

        if (adv) begin
            run_d  = 1'b1;
            hpos_d = h_wrap ? '0 : CW'(hpos + 1'b1);
            if (h_wrap) begin
                vpos_d = v_wrap ? '0 : CW'(vpos + 1'b1);
            end
        end

        hs_win  = (hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST);
        vs_win  = (vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST);
        act_win = (hpos_d <= H_ACT_LAST) && (vpos_d <= V_ACT_LAST);
    end

    // State, counters and all outputs; IDLE keeps syncs inactive and display off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            display_on  <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            hpos        <= hpos_d;
            vpos        <= vpos_d;
            state       <= run_d ? RUN : IDLE;
            hsync       <= (run_d && hs_win) ? HS_ON : ~HS_ON;
            vsync       <= (run_d && vs_win) ? VS_ON : ~VS_ON;
            display_on  <= run_d && act_win;
            pix_tick    <= adv;
            line_start  <= adv && h_wrap;
            frame_start <= adv && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int hpol, vpol, div;
    } cfg_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
    localparam cfg_t CFG_B = '{640, 16, 96, 48, 4, 1, 1, 1, 0, 0, 4};
    localparam cfg_t CFG_C = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 1};
    localparam cfg_t CFG_D = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b0;

    logic       a_hs, a_vs, a_don, a_tk, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_hs, b_vs, b_don, b_tk, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_hs, c_vs, c_don, c_tk, c_ls, c_fs;
    logic [3:0] c_h, c_v;
    logic       d_hs, d_vs, d_don, d_tk, d_ls, d_fs;
    logic [3:0] d_h, d_v;

    int  n_chk = 0;
    int  n_pass = 0;
    bit  chk_on = 1'b0;
    int  e_cnt[4];
    bit  last_en[4];

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(a_hs), .vsync(a_vs),
        .display_on(a_don), .hpos(a_h), .vpos(a_v), .pix_tick(a_tk),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_don), .hpos(b_h), .vpos(b_v), .pix_tick(b_tk),
        .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(1), .CW(4)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(c_hs), .vsync(c_vs),
        .display_on(c_don), .hpos(c_h), .vpos(c_v), .pix_tick(c_tk),
        .line_start(c_ls), .frame_start(c_fs)
    );

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .CLK_DIV(3), .CW(4)) u_d (
        .clk(clk), .rst_n(rst_n), .ena(ena), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_don), .hpos(d_h), .vpos(d_v), .pix_tick(d_tk),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // Literal check helper.
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: the enabled clock edges since reset, e, determine everything.
    // There have been e/div pixel advances, and the raster position is that
    // count modulo the frame size.
    task automatic check_one(input string nm, input cfg_t c, input int e, input bit le,
                             input int ah, input int av, input bit ahs, input bit avs,
                             input bit adon, input bit atk, input bit als, input bit afs);
        int ht, vt, adv, p, h, v;
        bit run, xhs, xvs, xdon, xtk, xls, xfs;
        ht   = c.ha + c.hfp + c.hs + c.hbp;
        vt   = c.va + c.vfp + c.vs + c.vbp;
        adv  = e / c.div;
        run  = adv > 0;
        p    = adv % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        xhs  = (run && h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hpol[0] : !c.hpol[0];
        xvs  = (run && v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vpol[0] : !c.vpol[0];
        xdon = run && h < c.ha && v < c.va;
        xtk  = le && e > 0 && (e % c.div) == 0;
        xls  = xtk && h == 0;
        xfs  = xtk && p == 0;
        n_chk++;
        if (ah == h && av == v && ahs == xhs && avs == xvs && adon == xdon &&
            atk == xtk && als == xls && afs == xfs) begin
            n_pass++;
        end else begin
            $display("FAIL model_%s t=%0t: got h=%0d v=%0d hs=%0b vs=%0b don=%0b tk=%0b ls=%0b fs=%0b expected h=%0d v=%0d hs=%0b vs=%0b don=%0b tk=%0b ls=%0b fs=%0b",
                     nm, $time, ah, av, ahs, avs, adon, atk, als, afs,
                     h, v, xhs, xvs, xdon, xtk, xls, xfs);
        end
    endtask

    // Model update at every edge, compare of all four instances 1 time unit later.
    always begin
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                e_cnt[i]   = 0;
                last_en[i] = 1'b0;
            end else begin
                last_en[i] = ena;
                if (ena) e_cnt[i]++;
            end
        end
        #1;
        if (chk_on) begin
            check_one("A", CFG_A, e_cnt[0], last_en[0], int'(a_h), int'(a_v), a_hs, a_vs, a_don, a_tk, a_ls, a_fs);
            check_one("B", CFG_B, e_cnt[1], last_en[1], int'(b_h), int'(b_v), b_hs, b_vs, b_don, b_tk, b_ls, b_fs);
            check_one("C", CFG_C, e_cnt[2], last_en[2], int'(c_h), int'(c_v), c_hs, c_vs, c_don, c_tk, c_ls, c_fs);
            check_one("D", CFG_D, e_cnt[3], last_en[3], int'(d_h), int'(d_v), d_hs, d_vs, d_don, d_tk, d_ls, d_fs);
        end
    end

    initial begin
        int a_ls1, a_ls2, a_hs_low, b_ls1, b_ticks, c_fs1, c_fs2, c_hs_hi, c_vs_hi, a_fs_cnt;
        bit found;
        a_ls1 = 0; a_ls2 = 0; a_hs_low = 0; b_ls1 = 0; b_ticks = 0;
        c_fs1 = 0; c_fs2 = 0; c_hs_hi = 0; c_vs_hi = 0; a_fs_cnt = 0;

        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset values; held with ena low and no strobe on leaving reset.
        chk("rst_a_hpos", int'(a_h), 0);
        chk("rst_a_hsync", int'(a_hs), 1);
        chk("rst_a_don", int'(a_don), 0);
        chk("rst_a_fs", int'(a_fs), 0);
        chk("rst_c_hsync", int'(c_hs), 0);
        chk("rst_c_vsync", int'(c_vs), 0);

        // Continuous run: line/frame periods and sync widths.
        @(negedge clk) ena = 1'b1;
        for (int k = 1; k <= 3300; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                chk("first_a_hpos", int'(a_h), 1);
                chk("first_a_tick", int'(a_tk), 1);
                chk("first_a_don", int'(a_don), 1);
                chk("first_b_hpos", int'(b_h), 0);
            end
            if (k == 4) chk("b_hpos_k4", int'(b_h), 1);
            if (a_ls && a_ls1 == 0) a_ls1 = k;
            else if (a_ls && a_ls2 == 0) a_ls2 = k;
            if (k <= 800 && !a_hs) a_hs_low++;
            if (b_ls && b_ls1 == 0) b_ls1 = k;
            if (b_tk) b_ticks++;
            if (c_fs && c_fs1 == 0) c_fs1 = k;
            else if (c_fs && c_fs2 == 0) c_fs2 = k;
            if (k <= 98 && c_hs) c_hs_hi++;
            if (k <= 98 && c_vs) c_vs_hi++;
        end
        chk("a_line1", a_ls1, 800);
        chk("a_line2", a_ls2, 1600);
        chk("a_hsync_low", a_hs_low, 96);
        chk("b_line1", b_ls1, 3200);
        chk("b_ticks", b_ticks, 825);
        chk("c_frame1", c_fs1, 98);
        chk("c_frame2", c_fs2, 196);
        chk("c_hsync_hi", c_hs_hi, 14);
        chk("c_vsync_hi", c_vs_hi, 14);

        // Random run/freeze pattern.
        for (int k = 0; k < 15000; k++) begin
            @(negedge clk);
            ena = ($urandom_range(0, 9) < 7);
        end

        // Freeze at hpos 700 for 37 clocks.
        @(negedge clk) ena = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(posedge clk);
            #1;
            if (a_h == 10'd700) found = 1'b1;
        end
        chk("wait_hpos700", int'(found), 1);
        @(negedge clk) ena = 1'b0;
        for (int k = 0; k < 37; k++) begin
            @(posedge clk);
            #1;
            chk("freeze_hpos", int'(a_h), 700);
            chk("freeze_strobes", int'({a_tk, a_ls, a_fs}), 0);
        end
        @(negedge clk) ena = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_hpos", int'(a_h), 701);

        // Asynchronous reset in mid-cycle at hpos 300.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(posedge clk);
            #1;
            if (a_h == 10'd300) found = 1'b1;
        end
        chk("wait_hpos300", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_hpos", int'(a_h), 0);
        chk("arst_a_vpos", int'(a_v), 0);
        chk("arst_a_don", int'(a_don), 0);
        chk("arst_a_hsync", int'(a_hs), 1);
        chk("arst_c_hsync", int'(c_hs), 0);
        chk("arst_d_hsync", int'(d_hs), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("post_rst_a_hpos", int'(a_h), 1);
            if (a_fs) a_fs_cnt++;
        end
        chk("post_rst_no_frame", a_fs_cnt, 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
